icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 4, words (4 bytes each) per cache block; power of two, 1..16.
REQ-002 SHALL have parameter XLEN, default 32, address width, taken from the shared defines.
REQ-003 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_DataReq  input  1  cache refill request, held high while the cache allocates.
REQ-006 SHALL have port i_MemAddr  input  XLEN  miss address from the cache.
REQ-007 SHALL have port o_DataBlock  output  BLOCK_SIZE*32  assembled block; word k at bits [32k+31:32k].
REQ-008 SHALL have port o_MemReady  output  1  one-cycle pulse: o_DataBlock complete and valid.
REQ-009 SHALL have port o_BusReq  output  1  word read request to memory bus.
REQ-010 SHALL have port o_BusAddr  output  XLEN  word address of current request, low 2 bits zero.
REQ-011 SHALL have port i_BusAck  input  1  bus accepts request; i_BusData valid in the same cycle.
REQ-012 SHALL have port i_BusData  input  32  read data word.
REQ-013 SHALL have port o_Busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DONE, DRAIN.
REQ-015 IDLE: if i_DataReq=1, SHALL latch base = i_MemAddr with low log2(BLOCK_SIZE)+2 bits cleared, clear beat counter, go to FETCH.
REQ-016 FETCH: SHALL drive o_BusReq=1 and o_BusAddr = base + 4*beat; both held stable until i_BusAck.
REQ-017 On i_BusAck in FETCH SHALL write i_BusData into word slot [beat] and increment beat.
REQ-018 On i_BusAck with beat = BLOCK_SIZE-1 SHALL go to DONE; counter width log2(BLOCK_SIZE)+1, no wrap inside a refill.
REQ-019 DONE: SHALL assert o_MemReady for exactly one cycle, o_BusReq=0, then go to IDLE.
REQ-020 o_DataBlock SHALL stay stable from DONE until the first i_BusAck of the next refill.
REQ-021 Minimum refill latency: 1 (IDLE accept) + BLOCK_SIZE (zero-wait acks) + 1 (DONE) cycles from i_DataReq rise to o_MemReady.
REQ-022 Wait states: each cycle with o_BusReq=1 and i_BusAck=0 SHALL add one cycle; no timeout.
REQ-023 Abort: i_DataReq=0 in FETCH with i_BusAck=0 SHALL drop o_BusReq next cycle and go to IDLE, no o_MemReady.
REQ-024 Abort with simultaneous i_BusAck SHALL store the word, then go to DRAIN; DRAIN SHALL last one cycle, o_BusReq=0, no o_MemReady, then IDLE.
REQ-025 i_MemAddr changes after acceptance SHALL be ignored until IDLE.
REQ-026 i_DataReq high in the cycle after DONE SHALL start a new refill (back-to-back misses), no dead cycle beyond IDLE accept.
REQ-027 BLOCK_SIZE=1 SHALL degenerate to a single beat at i_MemAddr[XLEN-1:2],2'b00.
REQ-028 i_BusAck outside FETCH SHALL be ignored.

Reset
REQ-029 On i_rst=0 at a clock edge: state IDLE, beat 0, base 0, o_DataBlock 0, o_MemReady 0, o_BusReq 0, o_BusAddr 0, o_Busy 0.
REQ-030 Reset mid-refill SHALL take priority over any ack in that cycle and discard partial data.

Structure
REQ-031 State encoding localparams SHALL reside in the shared defines header next to XLEN; no other shared types.
REQ-032 Single flat module, no sub-module; one registered FSM plus one combinational next-state block.
REQ-033 All outputs SHALL be registered or decoded from state only; no combinational path from i_BusAck to o_BusReq.

Verification
REQ-034 Reset then i_DataReq=1, i_MemAddr=0x0000_1034, BLOCK_SIZE=4, acks every cycle with data 0xA0..0xA3 -> o_BusAddr 0x1030,0x1034,0x1038,0x103C; o_MemReady pulse cycle 6; o_DataBlock=0x000000A3_000000A2_000000A1_000000A0.
REQ-035 Same request, 2 wait cycles before every ack -> o_BusAddr held stable during waits; o_MemReady cycle 14; identical block.
REQ-036 Drop i_DataReq after beat 1 with no ack -> o_BusReq low next cycle, no o_MemReady, o_Busy 0 within 1 cycle.
REQ-037 Drop i_DataReq in cycle of beat-2 ack -> DRAIN one cycle, no o_MemReady, next request 0x2000 fetches from 0x2000.
REQ-038 i_rst=0 during beat 2 with i_BusAck=1 -> all outputs zero next cycle, state IDLE.
REQ-039 Back-to-back requests 0x100 then 0x200, BLOCK_SIZE=1 -> two o_MemReady pulses, blocks match bus data, no spurious o_BusReq between.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared defines for the instruction cache refill engine:
// default address width and refill FSM state encodings.
package icache_refill_pkg;

   localparam int DEF_XLEN = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/icache_refill.sv
// icache_refill: fetches one cache block word-by-word over a simple
// req/ack bus and presents the assembled block to the cache.
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_DataReq, i_MemAddr  refill request and miss address from cache
//   o_DataBlock           assembled block, word k at [32k+31:32k]
//   o_MemReady            one-cycle pulse, block complete
//   o_BusReq, o_BusAddr   word read request and word address to bus
//   i_BusAck, i_BusData   bus accept, read data valid same cycle
//   o_Busy                engine not idle
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter int BLOCK_SIZE = 4,
   parameter int XLEN       = DEF_XLEN
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_DataReq,
   input  logic [XLEN-1:0]         i_MemAddr,
   output logic [BLOCK_SIZE*32-1:0] o_DataBlock,
   output logic                    o_MemReady,
   output logic                    o_BusReq,
   output logic [XLEN-1:0]         o_BusAddr,
   input  logic                    i_BusAck,
   input  logic [31:0]             i_BusData,
   output logic                    o_Busy
);

   localparam int OFFW = $clog2(BLOCK_SIZE) + 2;
   localparam int CW   = $clog2(BLOCK_SIZE) + 1;

   localparam logic [XLEN-1:0] OFF_MASK =
      XLEN'((64'd1 << OFFW) - 64'd1);

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      FETCH = ST_FETCH,
      DONE  = ST_DONE,
      DRAIN = ST_DRAIN
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [XLEN-1:0]         r_base;
   logic [CW-1:0]           r_beat;
   logic [BLOCK_SIZE*32-1:0] r_block;
   logic                    w_last;

   assign w_last = (r_beat == CW'(BLOCK_SIZE - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (i_DataReq) w_next = FETCH;
         end
         FETCH: begin
            // an abort that coincides with an ack keeps the word,
            // then spends one cycle in DRAIN before going idle
            if (i_BusAck) begin
               if (!i_DataReq)  w_next = DRAIN;
               else if (w_last) w_next = DONE;
            end else if (!i_DataReq) begin
               w_next = IDLE;
            end
         end
         DONE:  w_next = IDLE;
         DRAIN: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_base  <= '0;
         r_beat  <= '0;
         r_block <= '0;
      end else begin
         if (r_state == IDLE && i_DataReq) begin
            r_base <= i_MemAddr & ~OFF_MASK;
            r_beat <= '0;
         end
         if (r_state == FETCH && i_BusAck) begin
            r_block[int'(r_beat)*32 +: 32] <= i_BusData;
            r_beat <= r_beat + CW'(1);
         end
      end
   end

   // bus outputs depend only on registered state, never on i_BusAck
   assign o_BusReq    = (r_state == FETCH);
   assign o_BusAddr   = r_base + (XLEN'(r_beat) << 2);
   assign o_MemReady  = (r_state == DONE);
   assign o_Busy      = (r_state != IDLE);
   assign o_DataBlock = r_block;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill (BLOCK_SIZE 4 and 1).
// Expected addresses and blocks are queued at stimulus time.
module tb_icache_refill;

   logic         clk = 0;
   logic         rst_n;
   logic         req4, ack4, rdy4, breq4, busy4;
   logic [31:0]  addr4, data4, baddr4;
   logic [127:0] blk4;
   logic         req1, ack1, rdy1, breq1, busy1;
   logic [31:0]  addr1, data1, baddr1, blk1;

   int total = 0;
   int bad   = 0;

   logic [31:0]  q_addr[$];
   logic [127:0] q_blk[$];

   always #5 clk = ~clk;

   icache_refill #(.BLOCK_SIZE(4), .XLEN(32)) u4 (
      .i_clk(clk), .i_rst(rst_n),
      .i_DataReq(req4), .i_MemAddr(addr4),
      .o_DataBlock(blk4), .o_MemReady(rdy4),
      .o_BusReq(breq4), .o_BusAddr(baddr4),
      .i_BusAck(ack4), .i_BusData(data4),
      .o_Busy(busy4)
   );

   icache_refill #(.BLOCK_SIZE(1), .XLEN(32)) u1 (
      .i_clk(clk), .i_rst(rst_n),
      .i_DataReq(req1), .i_MemAddr(addr1),
      .o_DataBlock(blk1), .o_MemReady(rdy1),
      .o_BusReq(breq1), .o_BusAddr(baddr1),
      .i_BusAck(ack1), .i_BusData(data1),
      .o_Busy(busy1)
   );

   task automatic check(input string tag,
                        input logic [127:0] got,
                        input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pop_addr(input string tag);
      if (q_addr.size() == 0) check({tag, "_q"}, 128'(1), 128'(0));
      else check(tag, 128'(baddr4), 128'(q_addr.pop_front()));
   endtask

   task automatic run_refill(input logic [31:0] addr,
                             input int waits,
                             input logic [31:0] dbase,
                             input int exp_cyc);
      logic [31:0]  base;
      logic [127:0] blk;
      int edges, wc, beat;
      bit done;
      base = addr & ~32'hF;
      for (int k = 0; k < 4; k++) begin
         q_addr.push_back(base + 32'(4 * k));
         blk[32*k +: 32] = dbase + 32'(k);
      end
      q_blk.push_back(blk);
      req4 = 1; addr4 = addr; ack4 = 0;
      edges = 0; wc = 0; beat = 0; done = 0;
      while (!done && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         addr4 = 32'hDEAD_BEE0;
         ack4  = 0;
         if (rdy4) begin
            check("rdy_cyc", 128'(edges + 1), 128'(exp_cyc));
            check("block", blk4, q_blk.pop_front());
            req4 = 0;
            done = 1;
         end else if (breq4) begin
            if (wc == waits) begin
               pop_addr("addr");
               ack4  = 1;
               data4 = dbase + 32'(beat);
               beat++;
               wc = 0;
            end else begin
               if (q_addr.size() > 0)
                  check("addr_hold", 128'(baddr4), 128'(q_addr[0]));
               wc++;
            end
         end
      end
      if (!done) check("timeout", 128'(0), 128'(1));
      step();
      check("rdy_pulse", 128'(rdy4), 128'(0));
      check("idle", 128'(busy4), 128'(0));
   endtask

   initial begin
      int nrdy, nreq, edges;
      rst_n = 0;
      req4 = 0; addr4 = 0; ack4 = 0; data4 = 0;
      req1 = 0; addr1 = 0; ack1 = 0; data1 = 0;
      step(); step();
      check("rst_blk", blk4, 128'(0));
      check("rst_rdy", 128'(rdy4), 128'(0));
      check("rst_breq", 128'(breq4), 128'(0));
      check("rst_baddr", 128'(baddr4), 128'(0));
      check("rst_busy", 128'(busy4), 128'(0));
      rst_n = 1;
      step();

      // zero-wait refill, then two wait states per beat
      run_refill(32'h0000_1034, 0, 32'hA0, 6);
      step();
      check("blk_hold", blk4,
            128'h000000A3_000000A2_000000A1_000000A0);
      run_refill(32'h0000_1034, 2, 32'hA0, 14);

      // abort with no ack while beat 1 is requested
      req4 = 1; addr4 = 32'h1034; ack4 = 0;
      step();
      check("ab1_breq", 128'(breq4), 128'(1));
      ack4 = 1; data4 = 32'h55;
      step();
      check("ab1_addr", 128'(baddr4), 128'(32'h1034));
      req4 = 0; ack4 = 0;
      step();
      check("ab1_breq0", 128'(breq4), 128'(0));
      check("ab1_busy0", 128'(busy4), 128'(0));
      check("ab1_rdy0", 128'(rdy4), 128'(0));

      // abort coincident with the beat-2 ack
      req4 = 1; addr4 = 32'h1034;
      step();
      ack4 = 1; data4 = 32'hB0;
      step();
      data4 = 32'hB1;
      step();
      check("ab2_addr", 128'(baddr4), 128'(32'h1038));
      data4 = 32'hB2; req4 = 0;
      step();
      ack4 = 0;
      check("drain_breq", 128'(breq4), 128'(0));
      check("drain_busy", 128'(busy4), 128'(1));
      check("drain_rdy", 128'(rdy4), 128'(0));
      check("drain_word", 128'(blk4[95:64]), 128'(32'hB2));
      step();
      check("drain_idle", 128'(busy4), 128'(0));
      check("drain_rdy2", 128'(rdy4), 128'(0));
      run_refill(32'h0000_2000, 0, 32'hC0, 6);

      // reset during the beat-2 ack
      req4 = 1; addr4 = 32'h1034;
      step();
      ack4 = 1; data4 = 32'hE0;
      step();
      data4 = 32'hE1;
      step();
      data4 = 32'hE2; rst_n = 0;
      step();
      ack4 = 0; req4 = 0;
      check("rr_blk", blk4, 128'(0));
      check("rr_rdy", 128'(rdy4), 128'(0));
      check("rr_breq", 128'(breq4), 128'(0));
      check("rr_baddr", 128'(baddr4), 128'(0));
      check("rr_busy", 128'(busy4), 128'(0));
      rst_n = 1;
      step();

      // back-to-back single-word refills on the BLOCK_SIZE=1 unit
      q_addr.delete();
      q_blk.delete();
      q_addr.push_back(32'h100);
      q_addr.push_back(32'h200);
      q_blk.push_back(128'(32'hD1));
      q_blk.push_back(128'(32'hD2));
      req1 = 1; addr1 = 32'h100;
      nrdy = 0; nreq = 0; edges = 0;
      while (nrdy < 2 && edges < 50) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         ack1 = 0;
         if (rdy1) begin
            check("b2b_blk", 128'(blk1), q_blk.pop_front());
            nrdy++;
            if (nrdy == 1) addr1 = 32'h200;
            else req1 = 0;
         end
         if (breq1) begin
            nreq++;
            if (q_addr.size() == 0) check("b2b_q", 128'(1), 128'(0));
            else check("b2b_addr", 128'(baddr1),
                       128'(q_addr.pop_front()));
            ack1  = 1;
            data1 = 32'hD0 + 32'(nreq);
         end
      end
      check("b2b_rdys", 128'(nrdy), 128'(2));
      check("b2b_reqs", 128'(nreq), 128'(2));
      check("b2b_cyc", 128'(edges), 128'(5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
